// File: rtl/aes_comp_pkg.sv
// Shared AES_Comp definitions: FSM encodings, GF(2^8) helpers, S-box functions and rcon decode.
package aes_comp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_KEXP = 2'd1;
  localparam logic [1:0] ST_DEC  = 2'd2;

  localparam logic [7:0] RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [9:0] sel);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (sel[i]) r = r | RCON_TBL[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/AES_Comp_SubBytesComp.sv
// Forward S-box applied to each byte of a 32-bit word (SubWord).
module AES_Comp_SubBytesComp
  import aes_comp_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      y[31-8*i -: 8] = sbox_fwd(x[31-8*i -: 8]);
    end
  end

endmodule

// File: rtl/aes_comp_dec_round.sv
// One inverse AES round plus the backward key-schedule step that yields k_{r-1} from k_r.
module aes_comp_dec_round
  import aes_comp_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic [9:0]   rrg,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] key_prev
);

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0] n1, n2, n3;
  logic [31:0]  sub_word;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;

  assign {w0, w1, w2, w3} = rkey;
  assign n3 = w3 ^ w2;
  assign n2 = w2 ^ w1;
  assign n1 = w1 ^ w0;

  AES_Comp_SubBytesComp u_subword (
    .x ({n3[23:0], n3[31:24]}),
    .y (sub_word)
  );

  assign key_prev = {w0 ^ sub_word ^ {rcon(rrg), 24'h000000}, n1, n2, n3};

  // Byte (r,c) sits at index r+4c; InvShiftRows pulls row r from column c-r.
  always_comb begin
    isb = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        isb[127-8*(r+4*c) -: 8] = sbox_inv(state[127-8*(r+4*((c+4-r)%4)) -: 8]);
      end
    end
    ark = isb ^ key_prev;
    imc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
    end
    next_state = last ? ark : imc;
  end

endmodule

// File: rtl/aes_comp_dec_core.sv
// Iterative AES-128 decryption core: one-time forward key expansion, then one round per cycle.
module aes_comp_dec_core
  import aes_comp_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [127:0] Kin,
  input  logic         Krdy,
  input  logic [127:0] Din,
  input  logic         Drdy,
  output logic [127:0] Dout,
  output logic         Kvld,
  output logic         Dvld,
  output logic         BSY
);

  logic [1:0]   state;
  logic [127:0] kreg;
  logic [127:0] kfin;
  logic [127:0] sreg;
  logic [9:0]   rrg;
  logic         kok;

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  sub_word;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] key_fwd;
  logic [127:0] s_next;
  logic [127:0] key_prev;

  assign {k0, k1, k2, k3} = kreg;

  AES_Comp_SubBytesComp u_subword (
    .x ({k3[23:0], k3[31:24]}),
    .y (sub_word)
  );

  assign f0 = k0 ^ sub_word ^ {rcon(rrg), 24'h000000};
  assign f1 = k1 ^ f0;
  assign f2 = k2 ^ f1;
  assign f3 = k3 ^ f2;
  assign key_fwd = {f0, f1, f2, f3};

  aes_comp_dec_round u_round (
    .state      (sreg),
    .rkey       (kreg),
    .rrg        (rrg),
    .last       (rrg[0]),
    .next_state (s_next),
    .key_prev   (key_prev)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      kreg  <= '0;
      kfin  <= '0;
      sreg  <= '0;
      rrg   <= '0;
      kok   <= 1'b0;
      Dout  <= '0;
      Kvld  <= 1'b0;
      Dvld  <= 1'b0;
      BSY   <= 1'b0;
    end else if (EN) begin
      Kvld <= 1'b0;
      Dvld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Krdy) begin
            kreg  <= Kin;
            rrg   <= 10'b0000000001;
            kok   <= 1'b0;
            BSY   <= 1'b1;
            state <= ST_KEXP;
          end else if (Drdy && kok) begin
            sreg  <= Din ^ kfin;
            kreg  <= kfin;
            rrg   <= 10'b1000000000;
            BSY   <= 1'b1;
            state <= ST_DEC;
          end
        end
        ST_KEXP: begin
          kreg <= key_fwd;
          rrg  <= rrg << 1;
          if (rrg[9]) begin
            kfin  <= key_fwd;
            kok   <= 1'b1;
            Kvld  <= 1'b1;
            BSY   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DEC: begin
          sreg <= s_next;
          kreg <= key_prev;
          rrg  <= rrg >> 1;
          if (rrg[0]) begin
            Dout  <= s_next;
            Dvld  <= 1'b1;
            BSY   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_comp_dec_core.sv
// Directed FIPS-197 and handshake vectors for aes_comp_dec_core.
module tb_aes_comp_dec_core;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b1;
  logic [127:0] Kin = '0;
  logic         Krdy = 1'b0;
  logic [127:0] Din = '0;
  logic         Drdy = 1'b0;
  logic [127:0] Dout;
  logic         Kvld;
  logic         Dvld;
  logic         BSY;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KFIN_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] JUNK    = 128'hdeadbeef0123456789abcdeffedcba98;

  always #5 CLK = ~CLK;

  aes_comp_dec_core dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .Kin  (Kin),
    .Krdy (Krdy),
    .Din  (Din),
    .Drdy (Drdy),
    .Dout (Dout),
    .Kvld (Kvld),
    .Dvld (Dvld),
    .BSY  (BSY)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts cycles from the strobe edge until the wanted pulse; also counts the other pulse.
  task automatic wait_pulse(input bit dec, input int stall_at, input int poke_at,
                            output int cycles, output int others);
    cycles = 1;
    others = 0;
    while (cycles < 40) begin
      if (dec ? Dvld : Kvld) break;
      if (dec ? Kvld : Dvld) others++;
      if (stall_at != 0 && cycles == stall_at) EN = 1'b0;
      if (stall_at != 0 && cycles == stall_at + 3) EN = 1'b1;
      Drdy = (poke_at != 0 && cycles == poke_at);
      if (Drdy) Din = JUNK;
      tick();
      cycles++;
    end
    Drdy = 1'b0;
    EN = 1'b1;
  endtask

  task automatic count_dvld(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (Dvld) seen++;
    end
  endtask

  task automatic strobe_key(input logic [127:0] k, input logic with_drdy);
    Kin = k; Krdy = 1'b1; Drdy = with_drdy; Din = CT_C1;
    tick();
    Krdy = 1'b0; Drdy = 1'b0;
  endtask

  task automatic strobe_dec(input logic [127:0] d);
    Din = d; Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
  endtask

  int cyc, oth, seen;

  initial begin
    repeat (3) tick();
    check("rst_dout", Dout, '0);
    check("rst_kvld", {127'd0, Kvld}, 128'd0);
    check("rst_dvld", {127'd0, Dvld}, 128'd0);
    check("rst_bsy", {127'd0, BSY}, 128'd0);
    RST = 1'b0;
    tick();

    strobe_dec(CT_C1);
    check("nokey_bsy", {127'd0, BSY}, 128'd0);
    count_dvld(14, seen);
    check("nokey_dvld", seen, 0);

    strobe_key(KEY_C1, 1'b0);
    check("c1_key_bsy", {127'd0, BSY}, 128'd1);
    wait_pulse(1'b0, 0, 0, cyc, oth);
    check("c1_kvld_lat", cyc, 11);
    check("c1_kvld_bsy", {127'd0, BSY}, 128'd0);
    check("c1_kfin", dut.kfin, KFIN_C1);
    tick();
    check("c1_kvld_1cyc", {127'd0, Kvld}, 128'd0);

    strobe_dec(CT_C1);
    check("c1_dec_bsy", {127'd0, BSY}, 128'd1);
    wait_pulse(1'b1, 0, 0, cyc, oth);
    check("c1_dvld_lat", cyc, 11);
    check("c1_dout", Dout, PT_C1);
    tick();
    check("c1_dvld_1cyc", {127'd0, Dvld}, 128'd0);

    // Krdy and Drdy together: only the key expansion may run.
    strobe_key(KEY_B, 1'b1);
    wait_pulse(1'b0, 0, 0, cyc, oth);
    check("both_kvld_lat", cyc, 11);
    check("both_no_dvld", oth, 0);
    tick();

    // Drdy poked mid-block is ignored; then back-to-back issue in the Dvld cycle.
    strobe_dec(CT_B);
    wait_pulse(1'b1, 0, 4, cyc, oth);
    check("b_dvld_lat", cyc, 11);
    check("b_dout", Dout, PT_B);
    strobe_dec(CT_B);
    check("b2b_bsy", {127'd0, BSY}, 128'd1);
    wait_pulse(1'b1, 0, 0, cyc, oth);
    check("b2b_dvld_lat", cyc, 11);
    check("b2b_dout", Dout, PT_B);
    count_dvld(15, seen);
    check("b_single_dvld", seen, 0);

    strobe_key(KEY_C1, 1'b0);
    wait_pulse(1'b0, 0, 0, cyc, oth);
    check("c1b_kvld_lat", cyc, 11);
    strobe_dec(CT_C1);
    wait_pulse(1'b1, 4, 0, cyc, oth);
    check("en_dvld_lat", cyc, 14);
    check("en_dout", Dout, PT_C1);
    EN = 1'b0;
    tick();
    check("en_dvld_hold", {127'd0, Dvld}, 128'd1);
    EN = 1'b1;
    tick();
    check("en_dvld_drop", {127'd0, Dvld}, 128'd0);

    // Abort at round 5 with a synchronous reset.
    strobe_dec(CT_C1);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_dout", Dout, '0);
    check("abort_kvld", {127'd0, Kvld}, 128'd0);
    check("abort_dvld", {127'd0, Dvld}, 128'd0);
    check("abort_bsy", {127'd0, BSY}, 128'd0);
    check("abort_kok", {127'd0, dut.kok}, 128'd0);
    count_dvld(15, seen);
    check("abort_no_dvld", seen, 0);
    strobe_dec(CT_C1);
    check("abort_drdy_bsy", {127'd0, BSY}, 128'd0);
    count_dvld(15, seen);
    check("abort_drdy_dvld", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
